// File: rtl/mips32_mem_responder.sv
// Word-addressed instruction/data memory shared by a fetch port and a data port,
// round-robin arbitrated, with a program-loader write path usable while idle.
module mips32_mem_responder #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_i,
    input  logic [31:0]   if_addr_i,
    output logic          if_ack_o,
    output logic [31:0]   if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [31:0]   dm_addr_i,
    input  logic [31:0]   dm_wdata_i,
    output logic          dm_ack_o,
    output logic [31:0]   dm_rdata_o,
    output logic          err_o,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [31:0]   prog_data_i,
    output logic          prog_ready_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q;
    logic [31:0]   mem_q [0:DEPTH-1];
    logic          dm_last_q;
    logic          sel_dm_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          oor_q;
    logic          if_ack_q, dm_ack_q, err_q;
    logic [31:0]   if_rdata_q, dm_rdata_q;

    logic          grant_dm_d;
    logic          in_range;
    logic [AW-1:0] idx;

    // On a tie the port that did not win last time gets the grant.
    assign grant_dm_d = dm_req_i && (!if_req_i || !dm_last_q);
    assign in_range   = (addr_q[31:AW] == '0);
    assign idx        = addr_q[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dm_last_q  <= 1'b1;
            sel_dm_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            oor_q      <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (prog_we_i) begin
                        mem_q[prog_addr_i] <= prog_data_i;
                    end else if (if_req_i || dm_req_i) begin
                        sel_dm_q  <= grant_dm_d;
                        dm_last_q <= grant_dm_d;
                        addr_q    <= grant_dm_d ? dm_addr_i : if_addr_i;
                        we_q      <= grant_dm_d && dm_we_i;
                        wdata_q   <= dm_wdata_i;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Read-before-write: a store returns the word it overwrites.
                    rdata_q <= in_range ? mem_q[idx] : '0;
                    oor_q   <= !in_range;
                    if (we_q && in_range) mem_q[idx] <= wdata_q;
                    state_q <= RESP;
                end
                RESP: begin
                    if (sel_dm_q) begin
                        dm_ack_q   <= 1'b1;
                        dm_rdata_q <= rdata_q;
                    end else begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= rdata_q;
                    end
                    err_q   <= oor_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prog_ready_o = (state_q == IDLE) && prog_we_i && !rst;
    assign if_ack_o     = if_ack_q;
    assign dm_ack_o     = dm_ack_q;
    assign err_o        = err_q;
    assign if_rdata_o   = if_rdata_q;
    assign dm_rdata_o   = dm_rdata_q;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Randomized and directed stimulus against a transaction-level model of the responder.
module tb_mips32_mem_responder;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we, prog_we;
    logic [31:0]   if_addr, dm_addr, dm_wdata, prog_data;
    logic [AW-1:0] prog_addr;
    logic          if_ack, dm_ack, err, prog_ready;
    logic [31:0]   if_rdata, dm_rdata;

    mips32_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata), .err_o(err),
        .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
        .prog_ready_o(prog_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: whole transactions resolved at grant time, response
    // surfaces a fixed number of edges later.
    logic [31:0] m_mem [DEPTH];
    bit          m_dm_last;
    int          m_cnt;
    bit          p_dm, p_err;
    logic [31:0] p_rdata;
    bit          e_if_ack, e_dm_ack, e_err;
    logic [31:0] e_if_rdata, e_dm_rdata;

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_dm_last = 1; m_cnt = 0;
        e_if_ack = 0; e_dm_ack = 0; e_err = 0;
        e_if_rdata = '0; e_dm_rdata = '0;
    endtask

    task automatic model_edge();
        bit          pick_dm;
        logic [31:0] a;
        if (rst) begin
            m_reset();
            return;
        end
        e_if_ack = 0; e_dm_ack = 0; e_err = 0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                e_err = p_err;
                if (p_dm) begin e_dm_ack = 1; e_dm_rdata = p_rdata; end
                else      begin e_if_ack = 1; e_if_rdata = p_rdata; end
            end
        end else if (prog_we) begin
            m_mem[prog_addr] = prog_data;
        end else if (if_req || dm_req) begin
            pick_dm   = dm_req && !(if_req && m_dm_last);
            m_dm_last = pick_dm;
            a         = pick_dm ? dm_addr : if_addr;
            p_dm      = pick_dm;
            p_err     = (a >= DEPTH);
            p_rdata   = p_err ? 32'h0 : m_mem[a];
            if (pick_dm && dm_we && !p_err) m_mem[a] = dm_wdata;
            m_cnt = 2;
        end
    endtask

    // Inputs are set just after a negedge; one call advances one clock.
    task automatic cyc();
        #1;
        chk("prog_ready", {31'b0, prog_ready}, {31'b0, (m_cnt == 0) && prog_we && !rst});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("if_ack",   {31'b0, if_ack}, {31'b0, e_if_ack});
        chk("dm_ack",   {31'b0, dm_ack}, {31'b0, e_dm_ack});
        chk("err",      {31'b0, err},    {31'b0, e_err});
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("dm_rdata", dm_rdata, e_dm_rdata);
    endtask

    task automatic idle_in();
        if_req = 0; dm_req = 0; dm_we = 0; prog_we = 0;
    endtask

    task automatic req_if(input logic [31:0] a);
        if_addr = a; if_req = 1; cyc();
        if_req = 0; repeat (3) cyc();
    endtask

    task automatic req_dm(input bit we, input logic [31:0] a, input logic [31:0] d);
        dm_we = we; dm_addr = a; dm_wdata = d; dm_req = 1; cyc();
        dm_req = 0; dm_we = 0; repeat (3) cyc();
    endtask

    initial begin
        m_reset();
        rst = 1; idle_in();
        if_addr = '0; dm_addr = '0; dm_wdata = '0; prog_addr = '0; prog_data = '0;
        repeat (2) cyc();
        rst = 0; cyc();

        // Loader write then fetch of the same word
        prog_we = 1; prog_addr = 0; prog_data = 32'h2801000A; cyc();
        prog_we = 0;
        req_if(0);

        // Store then load, read-before-write
        req_dm(1, 4, 32'h55);
        req_dm(0, 4, 32'h0);

        // Both ports held high: acks alternate
        if_req = 1; if_addr = 0; dm_req = 1; dm_we = 0; dm_addr = 4;
        repeat (12) cyc();
        idle_in(); repeat (3) cyc();

        // Out-of-range store and load
        req_dm(1, 40, 32'hFFFF);
        req_dm(0, 40, 32'h0);
        req_dm(0, 8, 32'h0);

        // Reset during the ACCESS cycle of a store
        dm_we = 1; dm_addr = 3; dm_wdata = 32'hDEAD_BEEF; dm_req = 1; cyc();
        dm_req = 0; dm_we = 0; rst = 1; cyc();
        rst = 0; repeat (2) cyc();
        req_dm(0, 3, 32'h0);
        req_dm(1, 3, 32'h1234_5678);
        req_dm(0, 3, 32'h0);

        // Loader write wins over a concurrent data request
        prog_we = 1; prog_addr = 9; prog_data = 32'hA5A5_0009;
        dm_req = 1; dm_we = 0; dm_addr = 9; cyc();
        prog_we = 0; cyc();
        dm_req = 0; repeat (3) cyc();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if_req    = ($urandom_range(0, 2) == 0);
            dm_req    = ($urandom_range(0, 2) == 0);
            dm_we     = $urandom_range(0, 1);
            if_addr   = $urandom_range(0, 47);
            dm_addr   = $urandom_range(0, 47);
            dm_wdata  = $urandom;
            prog_we   = ($urandom_range(0, 7) == 0);
            prog_addr = AW'($urandom_range(0, DEPTH - 1));
            prog_data = $urandom;
            rst       = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rst = 0; idle_in(); repeat (3) cyc();
        for (int i = 0; i < DEPTH; i += 4) req_dm(0, i, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips32_mem_responder.md
MIPS32_MEM_RESPONDER -- requirements
Module: mips32_mem_responder

Interface
REQ-001 The block SHALL take parameter DEPTH, default 32, as the number of 32-bit words in the memory array.
REQ-002 The block SHALL take parameter AW, default 5, as the number of word-index bits, with DEPTH = 2**AW.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 if_req  input  1  instruction-fetch request, held high until if_ack.
REQ-006 if_addr  input  32  fetch word address.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetched instruction, valid while if_ack=1.
REQ-009 dm_req  input  1  data request, held high until dm_ack.
REQ-010 dm_we  input  1  data write enable (1 = store, 0 = load), sampled with dm_req.
REQ-011 dm_addr  input  32  data word address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_ack  output  1  one-cycle data completion pulse.
REQ-014 dm_rdata  output  32  load data, valid while dm_ack=1.
REQ-015 err  output  1  out-of-range flag, valid with either ack.
REQ-016 prog_we  input  1  program-loader write strobe.
REQ-017 prog_addr  input  AW  loader word index.
REQ-018 prog_data  input  32  loader write data.
REQ-019 prog_ready  output  1  high when a loader write is accepted this cycle.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP, and every state SHALL return to IDLE within 3 cycles.
REQ-021 In IDLE with prog_we=1, the block SHALL write prog_data to mem[prog_addr], assert prog_ready, ignore requests that cycle and stay in IDLE.
REQ-022 In IDLE with prog_we=0 and any request pending, the arbiter SHALL grant, latch the granted port's address, we and wdata, and move to ACCESS.
REQ-023 With both requests pending, the arbiter SHALL grant the port not granted last (round-robin); after reset, the data port SHALL be treated as last granted, so the fetch port wins the first tie.
REQ-024 In ACCESS, the block SHALL perform the array read or write using latched values only; input changes during ACCESS SHALL have no effect.
REQ-025 In ACCESS, an address of DEPTH or more SHALL suppress the write, force the read data to 0 and set err for the response.
REQ-026 In RESP, the block SHALL pulse exactly one ack (if_ack or dm_ack) for one cycle with rdata and err valid, then return to IDLE.
REQ-027 Latency SHALL be 3 cycles from the req-sampling edge to the ack cycle, and throughput SHALL be at most one access per 3 cycles.
REQ-028 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-029 A store's rdata SHALL be the old word at that address (read-before-write), and the new value SHALL be visible to any later access.
REQ-030 Outside the ack cycle, if_rdata and dm_rdata SHALL hold their last values, and err SHALL be 0.
REQ-031 Dropping req before ack SHALL NOT abort an access already granted; that access SHALL complete and ack.

Reset
REQ-032 While rst=1, the block SHALL force state to IDLE; if_ack, dm_ack, err and prog_ready to 0; if_rdata and dm_rdata to 0; all memory words to 0; and the round-robin pointer to "data last".
REQ-033 Reset asserted mid-access SHALL abandon the access with no ack and no write after release, and the first posedge after release SHALL sample in IDLE.

Verification
REQ-034 Reset, then prog_we writes 0x2801000A to index 0 -> fetch addr 0 gives if_ack 3 cycles after the req edge, if_rdata=0x2801000A, err=0.
REQ-035 Store 0x55 to addr 4 (old value 0), then load addr 4 -> store dm_rdata=0 and load dm_rdata=0x55, each acked in 3 cycles.
REQ-036 if_req and dm_req held high together for 12 cycles -> acks alternate if, dm, if, dm, at cycles 3, 6, 9, 12.
REQ-037 Store 0xFFFF to addr 40 -> dm_ack with err=1 and no array word changed; a load from addr 40 returns dm_rdata=0 with err=1.
REQ-038 rst pulsed during ACCESS of a store to addr 3 -> no ack, mem[3]=0, and a fresh request after release completes normally.
REQ-039 prog_we and dm_req asserted in the same IDLE cycle -> the loader write is taken (prog_ready=1), and the data access is granted the next cycle.
